// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM state encoding and product width for the sequential multiplier
package mult_pkg;
  localparam int PROD_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/lookahead_adder.sv
// lookahead_adder: 16-bit adder built from four 4-bit carry-lookahead groups
module lookahead_adder (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        ci_i,
  output logic [15:0] s_o,
  output logic        co_o
);
  logic [15:0] g, p;
  logic [16:0] c;
  assign g = a_i & b_i;
  assign p = a_i ^ b_i;
  assign c[0] = ci_i;
  for (genvar k = 0; k < 4; k++) begin : grp
    localparam int B = 4 * k;
    assign c[B+1] = g[B] | (p[B] & c[B]);
    assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
    assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & c[B]);
    assign c[B+4] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                  | (p[B+3] & p[B+2] & p[B+1] & g[B]) | (&p[B+3:B] & c[B]);
  end
  assign s_o = p ^ c[15:0];
  assign co_o = c[16];
endmodule

// File: rtl/mult_seq.sv
// mult_seq: shift-and-add unsigned multiplier, one multiplier bit per cycle
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  output logic              Ready,
  output logic              Busy,
  output logic              Done,
  output logic [PROD_W-1:0] Product
);
  localparam int CNT_W = $clog2(WIDTH);
  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q, mplier_q;
  logic [PROD_W-1:0]  acc_q, acc_d, addend, sum;
  logic [CNT_W-1:0]   cnt_q;
  logic               adder_co_unused;
  assign addend = {{(PROD_W-WIDTH){1'b0}}, mcand_q} << cnt_q;
  lookahead_adder u_add (
    .a_i (acc_q),
    .b_i (addend),
    .ci_i(1'b0),
    .s_o (sum),
    .co_o(adder_co_unused)
  );
  // accumulate the shifted multiplicand only when the current multiplier bit is set
  always_comb acc_d = mplier_q[cnt_q] ? sum : acc_q;
  // control FSM with operand latch, bit counter and accumulator
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (Start) begin
          state_q  <= RUN;
          mcand_q  <= A;
          mplier_q <= B;
          acc_q    <= '0;
          cnt_q    <= '0;
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign Ready   = state_q == IDLE;
  assign Busy    = state_q == RUN;
  assign Done    = state_q == DONE;
  assign Product = acc_q;
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: randomized and directed checks of mult_seq against a product/latency model
module tb_mult_seq;
  localparam int W = 8;
  logic Clk = 1'b0, Reset = 1'b0, Start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic Ready, Busy, Done;
  logic [15:0] Product;
  int errors = 0, checks = 0, done_cnt = 0;

  always #5 Clk = ~Clk;

  mult_seq #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B),
    .Ready(Ready), .Busy(Busy), .Done(Done), .Product(Product)
  );

  always @(negedge Clk) begin
    if (Done === 1'b1) done_cnt++;
    if (Busy === 1'b1) begin
      checks++;
      if (dut.adder_co_unused !== 1'b0) begin
        errors++;
        $display("FAIL carry_out: got %b want 0", dut.adder_co_unused);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Launch one operation from IDLE; scrambles operands after accept and waits (bounded) for Done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [15:0] prod, output int lat);
    A = a; B = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; A = W'($urandom); B = W'($urandom);
    lat = 0;
    while (Done !== 1'b1 && lat < 20) begin @(posedge Clk); #1; lat++; end
    prod = Product;
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start = 1'b1; A = 8'h05; B = 8'h07;
    repeat (2) @(posedge Clk); #1;
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", Ready); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
    checks++; if (Product !== 16'h0) begin errors++; $display("FAIL reset_product: got %h want 0000", Product); end
    Reset = 1'b0; Start = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [4] = '{8'h12, 8'hFF, 8'hFF, 8'h00};
    logic [W-1:0] tb [4] = '{8'h34, 8'hFF, 8'h00, 8'hFF};
    logic [15:0] prod, exp;
    int lat;
    for (int i = 0; i < 4; i++) begin
      exp = 16'(ta[i]) * 16'(tb[i]);
      run_op(ta[i], tb[i], prod, lat);
      checks++; if (lat !== W) begin errors++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, W); end
      checks++; if (prod !== exp) begin errors++; $display("FAIL dir_product[%0d]: got %h want %h", i, prod, exp); end
      @(posedge Clk); #1;
      checks++; if (Ready !== 1'b1 || Product !== exp) begin
        errors++; $display("FAIL dir_hold[%0d]: got ready=%b product=%h want ready=1 product=%h", i, Ready, Product, exp);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b;
    logic [15:0] prod, exp;
    int lat;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom); b = W'($urandom);
      exp = 16'(a) * 16'(b);
      run_op(a, b, prod, lat);
      checks++; if (lat !== W || prod !== exp) begin
        errors++; $display("FAIL rand[%0d] %h*%h: got lat=%0d product=%h want lat=%0d product=%h", i, a, b, lat, prod, W, exp);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_start_ignored;
    int d0, lat;
    d0 = done_cnt;
    A = 8'h12; B = 8'h34; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (2) @(posedge Clk); #1;
    Start = 1'b1; A = 8'h01; B = 8'h01;
    repeat (2) @(posedge Clk); #1;
    Start = 1'b0;
    lat = 4;
    while (Done !== 1'b1 && lat < 20) begin @(posedge Clk); #1; lat++; end
    checks++; if (lat !== W) begin errors++; $display("FAIL ignore_latency: got %0d want %0d", lat, W); end
    checks++; if (Product !== 16'h03A8) begin errors++; $display("FAIL ignore_product: got %h want 03a8", Product); end
    @(posedge Clk); #1;
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt - d0); end
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL ignore_ready: got %b want 1", Ready); end
  endtask

  task automatic test_reset_mid_run;
    int d0, lat;
    logic [15:0] prod;
    d0 = done_cnt;
    A = 8'h12; B = 8'h34; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    checks++; if (Ready !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) begin
      errors++; $display("FAIL midreset_flags: got ready=%b busy=%b done=%b want 1/0/0", Ready, Busy, Done);
    end
    checks++; if (Product !== 16'h0) begin errors++; $display("FAIL midreset_product: got %h want 0000", Product); end
    repeat (12) @(posedge Clk); #1;
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses want 0", done_cnt - d0); end
    run_op(8'h03, 8'h05, prod, lat);
    checks++; if (lat !== W || prod !== 16'h000F) begin
      errors++; $display("FAIL midreset_next: got lat=%0d product=%h want lat=%0d product=000f", lat, prod, W);
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_back_to_back;
    int last, n;
    last = -1; n = 0;
    A = 8'h02; B = 8'h03; Start = 1'b1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(posedge Clk); #1;
      if (Done === 1'b1) begin
        checks++; if (Product !== 16'h0006) begin errors++; $display("FAIL b2b_product[%0d]: got %h want 0006", n, Product); end
        if (last >= 0) begin
          checks++; if (cyc - last !== W + 2) begin errors++; $display("FAIL b2b_period[%0d]: got %0d want %0d", n, cyc - last, W + 2); end
        end
        last = cyc; n++;
      end
    end
    Start = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", n); end
    for (int i = 0; i < 20 && Ready !== 1'b1; i++) begin @(posedge Clk); #1; end
    checks++; if (Ready !== 1'b1) begin errors++; $display("FAIL b2b_idle: got %b want 1", Ready); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_start_ignored;
    test_reset_mid_run;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits; legal values 2..8.
REQ-002 SHALL have port: Clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port: Reset  input  1  synchronous reset, active-high.
REQ-004 SHALL have port: Start  input  1  request a new multiply; sampled only when Ready=1.
REQ-005 SHALL have port: A  input  WIDTH  multiplicand, unsigned.
REQ-006 SHALL have port: B  input  WIDTH  multiplier, unsigned.
REQ-007 SHALL have port: Ready  output  1  high only in IDLE.
REQ-008 SHALL have port: Busy  output  1  high only in RUN.
REQ-009 SHALL have port: Done  output  1  one-cycle pulse; Product is valid while it is high.
REQ-010 SHALL have port: Product  output  16  accumulated product, unsigned, zero-extended above 2*WIDTH.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE -> RUN on an edge where Start=1; at that edge, latch A into the multiplicand register and B into the multiplier register.
REQ-013 At the same edge, clear the accumulator and the bit counter to 0.
REQ-014 SHALL ignore Start in RUN and DONE, with no effect on state, operands or counter.
REQ-015 SHALL process multiplier bit[count] on each RUN edge: if the bit is 1, acc <= acc + (multiplicand << count) through the 16-bit adder with carry-in 0; otherwise acc is unchanged.
REQ-016 SHALL increment count by 1 on every RUN edge.
REQ-017 RUN -> DONE on the edge that processes bit WIDTH-1.
REQ-018 DONE -> IDLE unconditionally on the next edge.
REQ-019 Fixed latency: with Start accepted at edge k, Done=1 between edge k+WIDTH and edge k+WIDTH+1, and Ready=1 again from edge k+WIDTH+1.
REQ-020 SHALL not skip cycles early when the multiplier is 0 or its upper bits are 0.
REQ-021 Product SHALL equal acc at all times; it holds the final value through DONE and IDLE until the next accepted Start clears it.
REQ-022 The shifted addend SHALL be zero-extended to 16 bits; the adder carry-out SHALL be ignored.
REQ-023 The adder carry-out is never 1 for legal WIDTH; the bench asserts this.
REQ-024 Minimum back-to-back period: Start held high continuously yields one operation every WIDTH+2 cycles.
REQ-025 Operand inputs A and B may change freely after the accept edge without affecting the result.

Reset
REQ-026 On Reset=1 at an edge, from any state including mid-RUN: state=IDLE, acc=0, count=0, operand registers=0.
REQ-027 Resulting outputs after such a reset edge: Ready=1, Busy=0, Done=0, Product=0.
REQ-028 Reset SHALL take priority over Start at the same edge.
REQ-029 An operation interrupted by Reset SHALL produce no Done pulse.

Structure
REQ-030 The FSM state enum (IDLE, RUN, DONE) and the constant PROD_W=16 SHALL live in shared package mult_pkg.
REQ-031 SHALL instantiate exactly one sub-module: the team's 16-bit carry-lookahead adder lookahead_adder, used for all accumulation.
REQ-032 Control, counter and shift logic SHALL be local to mult_seq.
REQ-033 No other arithmetic operator SHALL be used for accumulation.

Verification
REQ-034 Scenario 1: A=0x12, B=0x34, Start pulse -> Done exactly 8 cycles after accept, Product=0x03A8.
REQ-035 Scenario 2: A=0xFF, B=0xFF -> Product=0xFE01; carry-out never asserted.
REQ-036 Scenario 3: A=0xFF, B=0x00 and A=0x00, B=0xFF -> Product=0x0000, same 8-cycle latency.
REQ-037 Scenario 4: Start re-pulsed with A=0x01, B=0x01 during RUN of 0x12*0x34 -> ignored, result 0x03A8, single Done pulse.
REQ-038 Scenario 5: Reset asserted on the 4th RUN edge -> next cycle Ready=1, Product=0, no Done pulse; a following 0x03*0x05 gives 0x000F.
REQ-039 Scenario 6: Start held high with A=0x02, B=0x03 -> Done pulses every 10 cycles, each with Product=0x0006.
